// File: rtl/mips_pkg.sv
// Shared MIPS core types: fetch FSM states and
// instruction-register lane decode.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    DONE,
    ERR
  } fetch_state_e;

  function automatic logic [3:0] lane_onehot(
    input logic [1:0] idx,
    input logic       big_endian
  );
    logic [1:0] lane;
    lane = big_endian ? ~idx : idx;
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Byte-serial instruction fetch: four byte reads
// assemble one word into the instruction register.
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        abort_i,
  input  logic        mem_ready_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  IRWrite_o,
  output logic        fetch_en_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   base_q;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_q;
  logic [31:0]   cur_addr;

  assign cur_addr = base_q + {30'd0, byte_cnt};

  always_comb begin
    state_d    = state_q;
    mem_rd_o   = 1'b0;
    mem_addr_o = 32'd0;
    IRWrite_o  = 4'd0;
    fetch_en_o = 1'b0;
    err_o      = 1'b0;
    busy_o     = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i)
          state_d = READ;
      end
      READ: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = cur_addr;
        state_d    = WAIT;
      end
      WAIT: begin
        mem_addr_o = cur_addr;
        if (mem_ready_i) begin
          IRWrite_o = lane_onehot(byte_cnt, BIG_ENDIAN);
          state_d   = (byte_cnt == 2'd3) ? DONE : READ;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end
      end
      DONE: begin
        fetch_en_o = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        err_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush wins over any completion or lane write this cycle
    if (abort_i && state_q != IDLE) begin
      state_d    = IDLE;
      IRWrite_o  = 4'd0;
      fetch_en_o = 1'b0;
      err_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_q   <= 32'd0;
      byte_cnt <= 2'd0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == READ) begin
        base_q   <= pc_i;
        byte_cnt <= 2'd0;
      end
      if (state_q == WAIT && state_d == READ)
        byte_cnt <= byte_cnt + 2'd1;
      if (state_q == READ)
        tmo_q <= '0;
      else if (state_q == WAIT && !mem_ready_i)
        tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: two instances (LE/TIMEOUT=4,
// BE/TIMEOUT=15) checked against a transaction-level model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;

  logic        mem_rd   [2];
  logic [31:0] mem_addr [2];
  logic [3:0]  irw      [2];
  logic        fen      [2];
  logic        busy     [2];
  logic        err      [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.TIMEOUT(4), .BIG_ENDIAN(1'b0)) u_le (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
    .abort_i(abort), .mem_ready_i(ready),
    .mem_rd_o(mem_rd[0]), .mem_addr_o(mem_addr[0]),
    .IRWrite_o(irw[0]), .fetch_en_o(fen[0]),
    .busy_o(busy[0]), .err_o(err[0])
  );

  instr_fetch_ctrl #(.TIMEOUT(15), .BIG_ENDIAN(1'b1)) u_be (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
    .abort_i(abort), .mem_ready_i(ready),
    .mem_rd_o(mem_rd[1]), .mem_addr_o(mem_addr[1]),
    .IRWrite_o(irw[1]), .fetch_en_o(fen[1]),
    .busy_o(busy[1]), .err_o(err[1])
  );

  // Model: a fetch is "active" on byte k; each byte is
  // first issued, then waited for.
  int          to_p [2] = '{4, 15};
  bit          be_p [2] = '{1'b0, 1'b1};
  bit          m_act  [2];
  bit          m_iss  [2];
  bit          m_fin  [2];
  bit          m_fail [2];
  int          m_k    [2];
  int          m_w    [2];
  logic [31:0] m_pc   [2];

  logic        s_rd   [2];
  logic [31:0] s_addr [2];
  logic [3:0]  s_irw  [2];
  logic        s_fen  [2];
  logic        s_busy [2];
  logic        s_err  [2];

  function automatic logic [39:0] outs(int m);
    return {mem_rd[m], mem_addr[m], irw[m],
            fen[m], busy[m], err[m]};
  endfunction

  function automatic logic [3:0] rev4(logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic check(string name, logic [39:0] act,
                       logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 0; m_iss[m] = 0; m_fin[m] = 0;
      m_fail[m] = 0; m_k[m] = 0; m_w[m] = 0;
      m_pc[m] = 32'd0;
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      logic        e_busy, e_rd, e_fen, e_err;
      logic [31:0] e_addr;
      logic [3:0]  e_irw;
      int          lane;
      e_busy = m_act[m] || m_fin[m] || m_fail[m];
      e_rd   = m_act[m] && !m_iss[m];
      e_addr = m_act[m] ? m_pc[m] + 32'(m_k[m]) : 32'd0;
      lane   = be_p[m] ? 3 - m_k[m] : m_k[m];
      e_irw  = (m_act[m] && m_iss[m] && ready && !abort)
               ? 4'(1 << lane) : 4'd0;
      e_fen  = m_fin[m] && !abort;
      e_err  = m_fail[m] && !abort;
      check($sformatf("model_dut%0d", m), outs(m),
            {e_rd, e_addr, e_irw, e_fen, e_busy, e_err});
      check($sformatf("onehot_dut%0d", m),
            40'($onehot0(irw[m])), 40'd1);
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      bit b;
      b = m_act[m] || m_fin[m] || m_fail[m];
      if (b && abort) begin
        m_act[m] = 0; m_fin[m] = 0; m_fail[m] = 0;
      end else if (m_fin[m] || m_fail[m]) begin
        m_fin[m] = 0; m_fail[m] = 0;
      end else if (!m_act[m]) begin
        if (start && !abort) begin
          m_act[m] = 1; m_iss[m] = 0;
          m_k[m] = 0; m_pc[m] = pc;
        end
      end else if (!m_iss[m]) begin
        m_iss[m] = 1; m_w[m] = 0;
      end else if (ready) begin
        if (m_k[m] == 3) begin
          m_act[m] = 0; m_fin[m] = 1;
        end else begin
          m_k[m]++; m_iss[m] = 0;
        end
      end else begin
        m_w[m]++;
        if (m_w[m] == to_p[m]) begin
          m_act[m] = 0; m_fail[m] = 1;
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic [31:0] p,
                      input logic a, input logic r);
    @(negedge clk);
    start = s; pc = p; abort = a; ready = r;
    #1;
    model_check();
    for (int m = 0; m < 2; m++) begin
      s_rd[m] = mem_rd[m]; s_addr[m] = mem_addr[m];
      s_irw[m] = irw[m]; s_fen[m] = fen[m];
      s_busy[m] = busy[m]; s_err[m] = err[m];
    end
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; abort = 0; ready = 0; pc = 0;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_dut0", outs(0), 40'd0);
    check("reset_dut1", outs(1), 40'd0);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  irw;
    logic        fen;
    logic        busy;
  } vec_t;

  vec_t vt [11];

  initial begin
    int fcyc, errs, fens, na, ni;
    logic [31:0] exp_a [4];
    logic [3:0]  exp_i [4];

    vt[0]  = '{1, 32'h100, 0, 32'h0,   4'b0000, 0, 0};
    vt[1]  = '{0, 32'h0,   1, 32'h100, 4'b0000, 0, 1};
    vt[2]  = '{0, 32'h0,   0, 32'h100, 4'b0001, 0, 1};
    vt[3]  = '{0, 32'h0,   1, 32'h101, 4'b0000, 0, 1};
    vt[4]  = '{0, 32'h0,   0, 32'h101, 4'b0010, 0, 1};
    vt[5]  = '{0, 32'h0,   1, 32'h102, 4'b0000, 0, 1};
    vt[6]  = '{0, 32'h0,   0, 32'h102, 4'b0100, 0, 1};
    vt[7]  = '{0, 32'h0,   1, 32'h103, 4'b0000, 0, 1};
    vt[8]  = '{0, 32'h0,   0, 32'h103, 4'b1000, 0, 1};
    vt[9]  = '{0, 32'h0,   0, 32'h0,   4'b0000, 1, 1};
    vt[10] = '{0, 32'h0,   0, 32'h0,   4'b0000, 0, 0};

    rst = 1;
    model_reset();
    do_reset();

    // Zero-wait fetch, ready held high throughout
    for (int i = 0; i < 11; i++) begin
      step(vt[i].start, vt[i].pc, 0, 1);
      check($sformatf("zw_le_%0d", i),
            {s_rd[0], s_addr[0], s_irw[0], s_fen[0], s_busy[0]},
            {vt[i].rd, vt[i].addr, vt[i].irw, vt[i].fen,
             vt[i].busy});
      check($sformatf("zw_be_%0d", i),
            {s_rd[1], s_addr[1], s_irw[1], s_fen[1], s_busy[1]},
            {vt[i].rd, vt[i].addr, rev4(vt[i].irw), vt[i].fen,
             vt[i].busy});
    end

    // Three wait states per byte
    do_reset();
    step(1, 32'h200, 0, 0);
    fcyc = -1; errs = 0;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, m_act[0] && m_iss[0] && m_w[0] >= 3);
      if (s_fen[0]) fcyc = i;
      if (s_err[0]) errs++;
    end
    check("wait_fen_cycle", 40'(fcyc), 40'd21);
    check("wait_no_err", 40'(errs), 40'd0);

    // Timeout after byte 0
    do_reset();
    step(1, 32'h300, 0, 1);
    errs = 0; fens = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, m_act[0] && m_k[0] == 0);
      if (s_err[0]) errs++;
      if (s_fen[0]) fens++;
    end
    check("tmo_err_once", 40'(errs), 40'd1);
    check("tmo_no_fen", 40'(fens), 40'd0);
    check("tmo_idle", 40'(s_busy[0]), 40'd0);
    step(1, 32'h400, 0, 0);
    step(0, 0, 0, 0);
    check("tmo_restart", {s_busy[0], s_rd[0], s_addr[0]},
          {1'b1, 1'b1, 32'h400});

    // Abort with ready on the second byte
    do_reset();
    step(1, 32'h500, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("abort_irw", {s_irw[0], s_irw[1]}, 8'd0);
    step(0, 0, 0, 1);
    check("abort_idle", {s_busy[0], s_busy[1]}, 2'd0);
    fens = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      if (s_fen[0] || s_fen[1]) fens++;
    end
    check("abort_no_fen", 40'(fens), 40'd0);

    // Big-endian with address wrap
    do_reset();
    exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    exp_i = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    na = 0; ni = 0;
    step(1, 32'hFFFFFFFE, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      if (s_rd[1] && na < 4) begin
        check($sformatf("be_addr_%0d", na), s_addr[1], exp_a[na]);
        na++;
      end
      if (s_irw[1] != 0 && ni < 4) begin
        check($sformatf("be_irw_%0d", ni), s_irw[1], exp_i[ni]);
        ni++;
      end
    end
    check("be_counts", {na[7:0], ni[7:0]}, {8'd4, 8'd4});

    // Asynchronous reset between edges, mid-WAIT
    do_reset();
    step(1, 32'h600, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    start = 0; abort = 0; ready = 1;
    #1;
    check("pre_rst_irw", irw[0], 4'b0001);
    #1;
    rst = 1;
    #1;
    check("async_rst_dut0", outs(0), 40'd0);
    check("async_rst_dut1", outs(1), 40'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step(1, 32'h700, 0, 1);
    step(0, 0, 0, 1);
    check("post_rst_start", {s_busy[0], s_rd[0], s_addr[0]},
          {1'b1, 1'b1, 32'h700});

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = ($urandom % 4 == 0) ? 32'hFFFFFFFC + ($urandom % 4)
                              : $urandom;
      step($urandom % 3 == 0, p, $urandom % 20 == 0,
           $urandom % 10 < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
